// File: rtl/vx_alu_issue_arb.sv
// Round-robin issue arbiter sharing one ALU between NUM_REQS requesters.
// Multi-beat packets hold the grant until eop; the selected beat is registered once.
module vx_alu_issue_arb #(
    parameter int NUM_REQS  = 4,
    parameter int DATAW     = 64,
    parameter int PERF_W    = 32,
    localparam int REQ_SEL_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQS-1:0]       req_valid,
    input  logic [NUM_REQS*DATAW-1:0] req_data,
    input  logic [NUM_REQS-1:0]       req_sop,
    input  logic [NUM_REQS-1:0]       req_eop,
    output logic [NUM_REQS-1:0]       req_ready,
    output logic                      out_valid,
    output logic [DATAW-1:0]          out_data,
    output logic                      out_sop,
    output logic                      out_eop,
    output logic [REQ_SEL_W-1:0]      out_sel,
    input  logic                      out_ready,
    output logic [PERF_W-1:0]         perf_stalls
);

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } lock_state_e;

    lock_state_e            state_q, state_d;
    logic [REQ_SEL_W-1:0]   lock_idx_q, lock_idx_d;
    logic [REQ_SEL_W-1:0]   rr_ptr_q, rr_ptr_d;

    logic                   out_valid_q;
    logic [DATAW-1:0]       out_data_q;
    logic                   out_sop_q;
    logic                   out_eop_q;
    logic [REQ_SEL_W-1:0]   out_sel_q;
    logic [PERF_W-1:0]      perf_q;

    logic                   out_en;
    logic                   grant_valid;
    logic [REQ_SEL_W-1:0]   grant_idx;
    logic                   accept;
    logic                   sel_eop;
    logic                   stall;

    // (base + off) mod NUM_REQS, with off in [0, NUM_REQS)
    function automatic logic [REQ_SEL_W-1:0] rr_idx(input logic [REQ_SEL_W-1:0] base,
                                                    input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQS) begin
            s = s - NUM_REQS;
        end
        return REQ_SEL_W'(s);
    endfunction

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign out_en = ~out_valid_q | out_ready;

    // Scan downwards so the requester closest to rr_ptr wins the last write.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        if (state_q == ST_LOCKED) begin
            grant_valid = 1'b1;
            grant_idx   = lock_idx_q;
        end else begin
            for (int i = NUM_REQS - 1; i >= 0; i--) begin
                if (req_valid[rr_idx(rr_ptr_q, i)]) begin
                    grant_valid = 1'b1;
                    grant_idx   = rr_idx(rr_ptr_q, i);
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant_valid && out_en) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign accept  = grant_valid & out_en & req_valid[grant_idx];
    assign sel_eop = req_eop[grant_idx];
    assign stall   = (|req_valid) & ~accept;

    always_comb begin
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        rr_ptr_d   = rr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (sel_eop) begin
                        rr_ptr_d = rr_idx(grant_idx, 1);
                    end else begin
                        state_d    = ST_LOCKED;
                        lock_idx_d = grant_idx;
                    end
                end
            end
            ST_LOCKED: begin
                if (accept && sel_eop) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = rr_idx(lock_idx_q, 1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            lock_idx_q  <= '0;
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_sel_q   <= '0;
            perf_q      <= '0;
        end else begin
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
            rr_ptr_q   <= rr_ptr_d;
            if (out_en) begin
                out_valid_q <= accept;
                if (accept) begin
                    out_data_q <= req_data[int'(grant_idx) * DATAW +: DATAW];
                    out_sop_q  <= req_sop[grant_idx];
                    out_eop_q  <= sel_eop;
                    out_sel_q  <= grant_idx;
                end
            end
            if (stall) begin
                perf_q <= sat_inc(perf_q);
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_sop     = out_sop_q;
    assign out_eop     = out_eop_q;
    assign out_sel     = out_sel_q;
    assign perf_stalls = perf_q;

endmodule
